prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Serial program loader: assembles big-endian 32-bit words from a byte stream,
// writes them into instruction memory and releases the processor when done.
module prog_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              run,
  output logic              busy,
  output logic              load_done,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // A latched word_count of zero stands for a full memory image.
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  state_t            state_q, state_d;
  logic [ADDR_W:0]   wc_q, wc_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [23:0]       asm_q, asm_d;
  logic              we_d, run_d, busy_d, done_d;
  logic [ADDR_W-1:0] addr_d;
  logic [31:0]       wdata_d;
  logic [ADDR_W:0]   wl_d;
  logic [ADDR_W:0]   eff_count;
  logic [ADDR_W:0]   wl_inc;

  assign byte_ready = (state_q == S_LOAD);
  assign eff_count  = (wc_q == '0) ? DEPTH : wc_q;
  assign wl_inc     = words_loaded + {{ADDR_W{1'b0}}, 1'b1};

  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    cnt_d   = cnt_q;
    asm_d   = asm_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    addr_d  = mem_addr;
    wdata_d = mem_wdata;
    wl_d    = words_loaded;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_LOAD;
          wc_d    = word_count;
          cnt_d   = 2'd0;
          asm_d   = 24'd0;
          addr_d  = '0;
          wl_d    = '0;
        end
      end
      S_LOAD: begin
        if (abort) begin
          // Abort wins over a concurrently accepted byte: the partial word is dropped.
          state_d = S_IDLE;
          cnt_d   = 2'd0;
          asm_d   = 24'd0;
        end else if (byte_valid) begin
          cnt_d = cnt_q + 2'd1;
          asm_d = {asm_q[15:0], byte_in};
          if (cnt_q == 2'd3) begin
            we_d    = 1'b1;
            addr_d  = words_loaded[ADDR_W-1:0];
            wdata_d = {asm_q, byte_in};
            wl_d    = wl_inc;
            asm_d   = 24'd0;
            if (wl_inc == eff_count) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    run_d  = (state_d == S_DONE);
    busy_d = (state_d == S_LOAD);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wc_q         <= '0;
      cnt_q        <= 2'd0;
      asm_q        <= 24'd0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= 32'd0;
      run          <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      words_loaded <= '0;
    end else begin
      state_q      <= state_d;
      wc_q         <= wc_d;
      cnt_q        <= cnt_d;
      asm_q        <= asm_d;
      mem_we       <= we_d;
      mem_addr     <= addr_d;
      mem_wdata    <= wdata_d;
      run          <= run_d;
      busy         <= busy_d;
      load_done    <= done_d;
      words_loaded <= wl_d;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: the driver derives expected memory writes
// from the byte stream; a negedge monitor pops and compares every mem_we.
module tb_prog_loader;
  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W:0]   word_count = '0;
  logic [7:0]        byte_in = 8'd0;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              run;
  logic              busy;
  logic              load_done;
  logic [ADDR_W:0]   words_loaded;

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .word_count(word_count), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .run(run), .busy(busy), .load_done(load_done),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: every write must match the next expected write in order.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual addr=%0d data=%h expected no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(e.addr));
        check("wr_data", 64'(mem_wdata), 64'(e.data));
        check("wr_load_done", 64'(load_done), 64'(e.last));
        check("wr_words_loaded", 64'(words_loaded), 64'(e.addr + 1));
      end
    end else if (load_done === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL stray_load_done actual=1 expected=0 (no write)");
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_byte_ready"},   64'(byte_ready), 0);
    check({tag, "_mem_we"},       64'(mem_we), 0);
    check({tag, "_mem_addr"},     64'(mem_addr), 0);
    check({tag, "_mem_wdata"},    64'(mem_wdata), 0);
    check({tag, "_run"},          64'(run), 0);
    check({tag, "_busy"},         64'(busy), 0);
    check({tag, "_load_done"},    64'(load_done), 0);
    check({tag, "_words_loaded"}, 64'(words_loaded), 0);
  endtask

  // mode: 0 back-to-back, 1 valid pattern 1,0,0,1, 2 random gaps.
  // abort_at / reset_at: byte index at which to interrupt (-1 = never).
  task automatic feed(input logic [ADDR_W:0] wc, input logic [7:0] bytes[$],
                      input int mode, input int abort_at, input bit abort_with_byte,
                      input int reset_at, output bit completed);
    int          nwords;
    int          i;
    int          cyc;
    bit          v;
    logic [3:0]  pat;
    pat    = 4'b1001;
    nwords = (wc == 0) ? (1 << ADDR_W) : int'(wc);
    completed = 1'b0;

    start      = 1'b1;
    word_count = wc;
    abort      = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    abort = 1'b0;
    check("load_byte_ready", 64'(byte_ready), 1);
    check("load_busy", 64'(busy), 1);
    check("load_run", 64'(run), 0);

    i   = 0;
    cyc = 0;
    while (i < bytes.size()) begin
      if (mode == 0)      v = 1'b1;
      else if (mode == 1) v = pat[3 - (cyc % 4)];
      else                v = ($urandom_range(0, 2) != 0);

      if (i == reset_at) begin
        reset      = 1'b1;
        byte_valid = 1'b1;
        byte_in    = bytes[i];
        tick();
        reset      = 1'b0;
        byte_valid = 1'b0;
        return;
      end
      if (i == abort_at) begin
        abort = 1'b1;
        v     = abort_with_byte;
      end
      byte_valid = v;
      byte_in    = v ? bytes[i] : 8'($urandom);
      start      = ($urandom_range(0, 3) == 0);
      if (v && !abort && (i % 4 == 3)) begin
        wr_t e;
        e.addr = i / 4;
        e.data = {bytes[i-3], bytes[i-2], bytes[i-1], bytes[i]};
        e.last = (i / 4 == nwords - 1);
        exp_q.push_back(e);
      end
      tick();
      if (abort) begin
        abort      = 1'b0;
        byte_valid = 1'b0;
        start      = 1'b0;
        return;
      end
      if (v) i++;
      cyc++;
    end
    byte_valid = 1'b0;
    start      = 1'b0;
    completed  = 1'b1;
  endtask

  task automatic check_done(input string tag, input int nwords);
    check({tag, "_mem_we"},       64'(mem_we), 1);
    check({tag, "_load_done"},    64'(load_done), 1);
    check({tag, "_run"},          64'(run), 1);
    check({tag, "_byte_ready"},   64'(byte_ready), 0);
    check({tag, "_busy"},         64'(busy), 0);
    check({tag, "_words_loaded"}, 64'(words_loaded), 64'(nwords));
  endtask

  initial begin
    logic [7:0] b[$];
    bit         ok;

    repeat (3) tick();
    check_all_zero("reset_hold");
    reset = 1'b0;
    tick();
    check_all_zero("after_reset");

    // Two-word reference load, back-to-back.
    b = '{8'h80, 8'h08, 8'h80, 8'h14, 8'h80, 8'h10, 8'h80, 8'h0F};
    feed(7'd2, b, 0, -1, 1'b0, -1, ok);
    check("two_word_completed", 64'(ok), 1);
    check_done("two_word", 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("done_pulse_clears", 64'(load_done), 0);
    check("done_run_held", 64'(run), 1);
    check("done_count_held", 64'(words_loaded), 2);
    check("done_no_we", 64'(mem_we), 0);

    // Same load with the 1,0,0,1 valid pattern, restarted from DONE.
    feed(7'd2, b, 1, -1, 1'b0, -1, ok);
    check_done("stalled", 2);

    // Reload from DONE with a single zero word.
    b = '{8'h00, 8'h00, 8'h00, 8'h00};
    feed(7'd1, b, 0, -1, 1'b0, -1, ok);
    check_done("reload", 1);

    // Full memory image with random gaps, then extra bytes must not be written.
    b.delete();
    for (int k = 0; k < 4 * (1 << ADDR_W); k++) b.push_back(8'($urandom));
    feed(7'd0, b, 2, -1, 1'b0, -1, ok);
    check_done("full", 1 << ADDR_W);
    check("full_last_addr", 64'(mem_addr), 63);
    for (int k = 0; k < 8; k++) begin
      byte_valid = 1'b1;
      byte_in    = 8'($urandom);
      tick();
      check("full_no_ready", 64'(byte_ready), 0);
    end
    byte_valid = 1'b0;

    // Abort alone after six bytes: only word 0 is written.
    b.delete();
    for (int k = 0; k < 8; k++) b.push_back(8'($urandom));
    feed(7'd2, b, 0, 6, 1'b0, -1, ok);
    check("abort6_idle_ready", 64'(byte_ready), 0);
    check("abort6_run", 64'(run), 0);
    check("abort6_busy", 64'(busy), 0);
    check("abort6_count", 64'(words_loaded), 1);
    repeat (4) tick();
    check("abort6_still_idle", 64'(busy), 0);

    // Abort together with the final byte: abort wins.
    b = '{8'h12, 8'h34, 8'h56, 8'h78};
    feed(7'd1, b, 0, 3, 1'b1, -1, ok);
    check("abort_final_we", 64'(mem_we), 0);
    check("abort_final_done", 64'(load_done), 0);
    check("abort_final_run", 64'(run), 0);
    check("abort_final_busy", 64'(busy), 0);

    // Reset after two bytes: nothing written, everything cleared.
    b.delete();
    for (int k = 0; k < 8; k++) b.push_back(8'($urandom));
    feed(7'd2, b, 0, -1, 1'b0, 2, ok);
    check_all_zero("reset_mid");
    repeat (3) tick();
    check_all_zero("reset_mid_later");

    // Random short loads with random gaps.
    for (int n = 0; n < 6; n++) begin
      int nw;
      nw = $urandom_range(1, 8);
      b.delete();
      for (int k = 0; k < 4 * nw; k++) b.push_back(8'($urandom));
      feed(7'(nw), b, 2, -1, 1'b0, -1, ok);
      check_done("rand", nw);
    end

    repeat (4) tick();
    check("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
